// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI master: register map, CTRL field positions,
// engine state encoding and small edge-classification helpers.
package spi_shift_engine_pkg;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_DATA_OUT = 2'd1;
  localparam logic [1:0] ADDR_DATA_IN  = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int CTRL_CPHA_BIT = 0;
  localparam int CTRL_CPOL_BIT = 1;
  localparam int CTRL_SS_BIT   = 2;
  localparam int CTRL_DIV_LSB  = 3;
  localparam int CTRL_DIV_MSB  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TAIL  = 2'd3
  } engine_state_e;

  localparam logic [4:0] EDGE_FIRST        = 5'd1;
  localparam logic [4:0] EDGE_LAST         = 5'd16;
  localparam logic [4:0] EDGE_LAST_C0_MOSI = 5'd14;

  // Odd edges sample when cpha=0, even edges sample when cpha=1.
  function automatic logic is_sample_edge(input logic cpha, input logic [4:0] edge_num);
    return edge_num[0] ^ cpha;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..div while enabled, pulses o_tick at div.
// Held cleared while disabled so every transfer starts on a fresh half period.
module spi_clk_div #(
  parameter int DIV_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt_r;

  // Divider counter with wrap at i_div
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= '0;
    end else if (!i_en) begin
      cnt_r <= '0;
    end else if (cnt_r == i_div) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

  assign o_tick = i_en && (cnt_r == i_div);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI byte serialiser/deserialiser: full duplex, MSB first, all four modes.
// Slave select is handled by the register block; this engine only moves bits.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [7:0]       i_tx_data,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_rx_data,
  output logic             o_SCLK,
  output logic             o_MOSI,
  input  logic             i_MISO
);

  engine_state_e    state_r;
  logic [7:0]       tx_shift_r;
  logic [7:0]       rx_shift_r;
  logic [4:0]       edge_cnt_r;
  logic             cpol_r;
  logic             cpha_r;
  logic [DIV_W-1:0] div_r;
  logic             busy_r;
  logic             done_r;
  logic [7:0]       rx_data_r;
  logic             sclk_r;
  logic             mosi_r;
  logic             miso_sync1_r;
  logic             miso_sync2_r;
  logic             sample_d1_r;
  logic             sample_d2_r;

  logic             accept_s;
  logic             tick_s;
  logic             sample_now_s;
  logic             active_s;
  logic [7:0]       rx_next_s;

  assign active_s = (state_r != ST_IDLE);

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (active_s),
    .i_div   (div_r),
    .o_tick  (tick_s)
  );

  // Accept decode, sample-edge decode and the next receive shift value
  always_comb begin
    accept_s     = 1'b0;
    sample_now_s = 1'b0;
    rx_next_s    = rx_shift_r;
    if (state_r == ST_IDLE) begin
      accept_s = i_start;
    end else begin
      accept_s = 1'b0;
    end
    if (state_r == ST_SHIFT) begin
      sample_now_s = tick_s && is_sample_edge(cpha_r, edge_cnt_r);
    end else begin
      sample_now_s = 1'b0;
    end
    if (sample_d2_r) begin
      rx_next_s = {rx_shift_r[6:0], miso_sync2_r};
    end else begin
      rx_next_s = rx_shift_r;
    end
  end

  // Two-flop MISO synchroniser
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      miso_sync1_r <= 1'b0;
      miso_sync2_r <= 1'b0;
    end else begin
      miso_sync1_r <= i_MISO;
      miso_sync2_r <= miso_sync1_r;
    end
  end

  // Sample strobe delayed to line up with the synchroniser, so the captured bit
  // is the MISO level that was on the pin when the sampling SCLK edge launched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_d1_r <= 1'b0;
      sample_d2_r <= 1'b0;
    end else if (accept_s) begin
      sample_d1_r <= 1'b0;
      sample_d2_r <= 1'b0;
    end else begin
      sample_d1_r <= sample_now_s;
      sample_d2_r <= sample_d1_r;
    end
  end

  // Transfer FSM with shift registers, edge counter and registered pin outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      tx_shift_r <= 8'h00;
      rx_shift_r <= 8'h00;
      edge_cnt_r <= 5'd0;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      div_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rx_data_r  <= 8'h00;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      rx_shift_r <= rx_next_s;
      case (state_r)
        ST_IDLE: begin
          sclk_r <= cpol_r;
          busy_r <= 1'b0;
          if (i_start) begin
            tx_shift_r <= i_tx_data;
            rx_shift_r <= 8'h00;
            cpol_r     <= i_cpol;
            cpha_r     <= i_cpha;
            div_r      <= i_div;
            sclk_r     <= i_cpol;
            busy_r     <= 1'b1;
            edge_cnt_r <= 5'd0;
            state_r    <= ST_SETUP;
            if (!i_cpha) begin
              mosi_r <= i_tx_data[7];
            end
          end
        end
        ST_SETUP: begin
          if (tick_s) begin
            edge_cnt_r <= EDGE_FIRST;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick_s) begin
            sclk_r <= ~sclk_r;
            if (!cpha_r && !edge_cnt_r[0] && (edge_cnt_r <= EDGE_LAST_C0_MOSI)) begin
              mosi_r     <= tx_shift_r[6];
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end else if (cpha_r && edge_cnt_r[0]) begin
              mosi_r     <= tx_shift_r[7];
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end
            if (edge_cnt_r == EDGE_LAST) begin
              state_r <= ST_TAIL;
            end else begin
              edge_cnt_r <= edge_cnt_r + 5'd1;
            end
          end
        end
        ST_TAIL: begin
          if (tick_s) begin
            rx_data_r <= rx_next_s;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = busy_r;
  assign o_done    = done_r;
  assign o_rx_data = rx_data_r;
  assign o_SCLK    = sclk_r;
  assign o_MOSI    = mosi_r;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine: loopback, modelled slave,
// tied MISO, ignored starts, back-to-back transfers and mid-transfer reset.
module tb_spi_shift_engine;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_tx_data;
  logic       i_cpol;
  logic       i_cpha;
  logic [4:0] i_div;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_rx_data;
  logic       sclk;
  logic       mosi;
  logic       miso_s;

  // MISO source: 0 = loopback, 1 = modelled slave, 2 = tied
  logic [1:0] miso_mode;
  logic       tie_val;
  logic       slave_bit;
  logic [7:0] slave_byte;

  // SCLK monitor state
  logic       mon_clr;
  logic       mon_cpol;
  logic       mon_cpha;
  logic       prev_sclk;
  logic       prev_mosi;
  int         rises;
  int         samp_cnt;
  int         lead_cnt;
  int         unstable;
  logic [7:0] samp_byte;

  int total;
  int bad;

  assign miso_s = (miso_mode == 2'd0) ? mosi :
                  (miso_mode == 2'd1) ? slave_bit : tie_val;

  spi_shift_engine #(.DIV_W(5)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (i_start),
    .i_tx_data (i_tx_data),
    .i_cpol    (i_cpol),
    .i_cpha    (i_cpha),
    .i_div     (i_div),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_rx_data (o_rx_data),
    .o_SCLK    (sclk),
    .o_MOSI    (mosi),
    .i_MISO    (miso_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watches SCLK edges: counts rises, records MOSI on sample edges, plays slave
  always @(negedge clk) begin
    if (mon_clr) begin
      prev_sclk <= sclk;
      prev_mosi <= mosi;
      rises     <= 0;
      samp_cnt  <= 0;
      lead_cnt  <= 0;
      unstable  <= 0;
      samp_byte <= 8'h00;
      slave_bit <= 1'b0;
    end else begin
      prev_sclk <= sclk;
      prev_mosi <= mosi;
      if (sclk && !prev_sclk) begin
        rises <= rises + 1;
        if (mosi !== prev_mosi) unstable <= unstable + 1;
      end
      if (sclk != prev_sclk) begin
        if (sclk == (mon_cpol ^ ~mon_cpha)) begin
          samp_byte <= {samp_byte[6:0], mosi};
          samp_cnt  <= samp_cnt + 1;
        end
        if ((sclk == ~mon_cpol) && (lead_cnt < 8)) begin
          slave_bit <= slave_byte[3'(7 - lead_cnt)];
          lead_cnt  <= lead_cnt + 1;
        end
      end
    end
  end

  task automatic start_xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                            input logic [4:0] div);
    @(negedge clk);
    i_tx_data = tx;
    i_cpol    = cpol;
    i_cpha    = cpha;
    i_div     = div;
    mon_cpol  = cpol;
    mon_cpha  = cpha;
    i_start   = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    mon_clr = 1'b1;
  endtask

  // Returns cycles from the accept edge to o_done, or -1 if the budget expires
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int n = 1; (n <= budget) && (lat < 0); n++) begin
      @(posedge clk);
      #1;
      if (n == 1) mon_clr = 1'b0;
      if (o_done) lat = n;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
    total++; if (o_rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h want=00", o_rx_data); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_clr = 1'b0;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_mode0_loopback;
    int lat;
    miso_mode = 2'd0;
    start_xfer(8'hA5, 1'b0, 1'b0, 5'd0);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL m0_busy_after_accept got=%b want=1", o_busy); end
    wait_done(100, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL m0_latency got=%0d want=18", lat); end
    total++; if (o_rx_data !== 8'hA5) begin bad++; $display("FAIL m0_rx got=%h want=a5", o_rx_data); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL m0_busy_at_done got=%b want=0", o_busy); end
    total++; if (rises !== 8) begin bad++; $display("FAIL m0_rising_edges got=%0d want=8", rises); end
    total++; if (samp_byte !== 8'hA5) begin bad++; $display("FAIL m0_mosi_order got=%h want=a5", samp_byte); end
  endtask

  task automatic test_mode3_slave;
    int lat;
    miso_mode  = 2'd1;
    slave_byte = 8'h3C;
    start_xfer(8'hC3, 1'b1, 1'b1, 5'd3);
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_setup got=%b want=1", sclk); end
    wait_done(300, lat);
    total++; if (lat !== 72) begin bad++; $display("FAIL m3_latency got=%0d want=72", lat); end
    total++; if (o_rx_data !== 8'h3C) begin bad++; $display("FAIL m3_rx got=%h want=3c", o_rx_data); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL m3_mosi_stable got=%0d want=0", unstable); end
    total++; if (rises !== 8) begin bad++; $display("FAIL m3_rising_edges got=%0d want=8", rises); end
    total++; if (samp_byte !== 8'hC3) begin bad++; $display("FAIL m3_mosi_order got=%h want=c3", samp_byte); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_idle got=%b want=1", sclk); end
  endtask

  task automatic test_modes_1_2;
    int lat;
    logic [7:0] tx_tab [4]  = '{8'hD2, 8'h4B, 8'h96, 8'h1E};
    logic       pol_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       pha_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       tie_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] want;
    miso_mode = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tie_val = tie_tab[i];
      want    = tie_tab[i] ? 8'hFF : 8'h00;
      start_xfer(tx_tab[i], pol_tab[i], pha_tab[i], 5'd1);
      wait_done(200, lat);
      total++; if (lat !== 36) begin bad++; $display("FAIL m12_latency[%0d] got=%0d want=36", i, lat); end
      total++; if (o_rx_data !== want) begin bad++; $display("FAIL m12_rx[%0d] got=%h want=%h", i, o_rx_data, want); end
      total++; if (samp_byte !== tx_tab[i]) begin bad++; $display("FAIL m12_mosi_order[%0d] got=%h want=%h", i, samp_byte, tx_tab[i]); end
      total++; if (samp_cnt !== 8) begin bad++; $display("FAIL m12_sample_edges[%0d] got=%0d want=8", i, samp_cnt); end
    end
  endtask

  task automatic test_ignore_start;
    int done_cnt = 0;
    int done_at  = -1;
    int early    = 0;
    logic [7:0] rx_seen = 8'h00;
    miso_mode = 2'd0;
    start_xfer(8'h69, 1'b0, 1'b0, 5'd0);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) mon_clr = 1'b0;
      if (o_done) begin
        done_cnt++;
        done_at = n;
        rx_seen = o_rx_data;
      end
      if ((n < 18) && !o_busy) early++;
      i_start   = (n == 4) || (n == 9);
      i_tx_data = 8'hFF;
      i_cpol    = 1'b1;
      i_cpha    = 1'b1;
      i_div     = 5'd7;
    end
    i_start = 1'b0;
    i_cpol  = 1'b0;
    i_cpha  = 1'b0;
    i_div   = 5'd0;
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", done_cnt); end
    total++; if (done_at !== 18) begin bad++; $display("FAIL ign_done_cycle got=%0d want=18", done_at); end
    total++; if (early !== 0) begin bad++; $display("FAIL ign_busy_early got=%0d want=0", early); end
    total++; if (rx_seen !== 8'h69) begin bad++; $display("FAIL ign_rx got=%h want=69", rx_seen); end
  endtask

  task automatic test_back_to_back;
    int lat;
    miso_mode = 2'd0;
    start_xfer(8'h81, 1'b0, 1'b0, 5'd0);
    wait_done(100, lat);
    total++; if (o_rx_data !== 8'h81) begin bad++; $display("FAIL b2b_first_rx got=%h want=81", o_rx_data); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_in_done got=%b want=0", o_busy); end
    i_tx_data = 8'h5A;
    i_start   = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL b2b_second_busy got=%b want=1", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL b2b_done_cleared got=%b want=0", o_done); end
    wait_done(100, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL b2b_latency got=%0d want=18", lat); end
    total++; if (o_rx_data !== 8'h5A) begin bad++; $display("FAIL b2b_second_rx got=%h want=5a", o_rx_data); end
  endtask

  task automatic test_reset_mid;
    int lat;
    miso_mode = 2'd0;
    start_xfer(8'hF0, 1'b0, 1'b0, 5'd0);
    mon_clr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL rst_mid_sclk_before got=%b want=1", sclk); end
    rst_n = 1'b0;
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", o_done); end
    total++; if (o_rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rx got=%h want=00", o_rx_data); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rst_mid_sclk got=%b want=0", sclk); end
    total++; if (mosi !== 1'b0) begin bad++; $display("FAIL rst_mid_mosi got=%b want=0", mosi); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (o_rx_data !== 8'h00) begin bad++; $display("FAIL rst_rel_rx got=%h want=00", o_rx_data); end
    start_xfer(8'h96, 1'b0, 1'b0, 5'd2);
    wait_done(200, lat);
    total++; if (lat !== 54) begin bad++; $display("FAIL rst_rel_latency got=%0d want=54", lat); end
    total++; if (o_rx_data !== 8'h96) begin bad++; $display("FAIL rst_rel_rx_done got=%h want=96", o_rx_data); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_tx_data  = 8'h00;
    i_cpol     = 1'b0;
    i_cpha     = 1'b0;
    i_div      = 5'd0;
    miso_mode  = 2'd2;
    tie_val    = 1'b0;
    slave_byte = 8'h00;
    mon_clr    = 1'b1;
    mon_cpol   = 1'b0;
    mon_cpha   = 1'b0;

    test_reset();
    test_mode0_loopback();
    test_mode3_slave();
    test_modes_1_2();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
